mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BTN_ADDR, default 32'd1000, the MMIO address for the button input.
REQ-002 SHALL have parameter OUT_ADDR, default 32'd2000, the MMIO address for the output latch.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_we  input  1  processor request and write-enable.
REQ-006 SHALL have ports cpu_addr/cpu_wdata  input  32  processor address and write data.
REQ-007 SHALL have ports cpu_gnt/cpu_rvalid  output  1  processor grant pulse and read-data-valid pulse.
REQ-008 SHALL have port cpu_rdata  output  32  processor read data.
REQ-009 SHALL have ports aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata, mirroring the cpu_* ports for the auxiliary (loader/debug) requester.
REQ-010 SHALL have port ram_wEn  output  1  RAM write enable.
REQ-011 SHALL have port ram_addr  output  12  RAM word address.
REQ-012 SHALL have port ram_dataIn  output  32  RAM write data.
REQ-013 SHALL have port ram_dataOut  input  32  RAM read data, valid one cycle after the address is presented (synchronous read).
REQ-014 SHALL have port button_in  input  1  asynchronous button level.
REQ-015 SHALL have port button_out  output  1  registered output latch.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-017 In IDLE with at least one req high, SHALL latch the winner's owner, addr, we and wdata, then go to ACCESS; with no req high, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester, and after each grant the pointer SHALL point to the other requester.
REQ-019 With one requester active, that requester SHALL win regardless of the pointer.
REQ-020 In ACCESS, SHALL pulse the owner's gnt high for exactly one cycle and drive ram_addr = latched addr[11:0] and ram_dataIn = latched wdata.
REQ-021 In ACCESS, ram_wEn SHALL equal the latched we, except 0 when the latched addr equals BTN_ADDR or OUT_ADDR.
REQ-022 ACCESS with a write SHALL go to IDLE; ACCESS with a read SHALL go to RESP.
REQ-023 In RESP, SHALL pulse the owner's rvalid for one cycle, drive its rdata, then go to IDLE; the non-owner's rdata and rvalid SHALL be 0.
REQ-024 Read data SHALL be {31'b0, btn_sync} for BTN_ADDR, {31'b0, button_out} for OUT_ADDR, and ram_dataOut otherwise.
REQ-025 Latency SHALL be: req sampled at edge N, gnt in cycle N+1, rvalid/rdata in cycle N+2.
REQ-026 Throughput SHALL be one write per 2 cycles and one read per 3 cycles.
REQ-027 A write to OUT_ADDR SHALL set button_out = wdata[0] at the end of ACCESS; a write to BTN_ADDR SHALL be ignored.
REQ-028 Addresses of 4096 and above (other than the MMIO addresses) SHALL wrap to addr[11:0] with no error.
REQ-029 button_in SHALL pass through a 2-flop synchronizer; btn_sync SHALL be the second flop.
REQ-030 Requesters SHALL hold req, we, addr and wdata until gnt; changes after latching SHALL NOT affect the transaction.
REQ-031 A req dropped before it is granted SHALL be treated as withdrawn.
REQ-032 Outside ACCESS, ram_wEn SHALL be 0, and ram_addr and ram_dataIn SHALL be 0.

Reset
REQ-033 Reset SHALL force: state IDLE, pointer to cpu, all gnt/rvalid/rdata 0, ram_* 0, button_out 0, synchronizer flops 0.
REQ-034 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transaction: no gnt or rvalid after the reset edge, and no RAM write in that cycle.

Verification
REQ-035 Bench SHALL cover: cpu write addr 5 data 0xDEADBEEF, then cpu read addr 5 -> ram_wEn one cycle, then cpu_rvalid with rdata 0xDEADBEEF two cycles after the read req.
REQ-036 Bench SHALL cover: cpu and aux both requesting reads, held 4 transactions -> grants alternate cpu, aux, cpu, aux starting with cpu after reset.
REQ-037 Bench SHALL cover: cpu write 2000 data 1 -> button_out 1, ram_wEn stays 0, read of 2000 returns 1; write 1000 -> no effect.
REQ-038 Bench SHALL cover: button_in set to 1 -> read of 1000 returns 1 only when requested at least 2 cycles after the change, and 0 before that.
REQ-039 Bench SHALL cover: aux write addr 4101 data 7 -> ram_addr 5, and a cpu read of 5 returns 7.
REQ-040 Bench SHALL cover: reset pulsed during a read's ACCESS cycle -> no rvalid, state IDLE, pointer back to cpu, button_out 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a synchronous-read RAM, with a
// synchronized button input and a one-bit output latch mapped into the address space.
//
//   state  | meaning
//   IDLE   | waiting for a request; latches the winning transaction
//   ACCESS | grant pulse to the owner; RAM address/data/write-enable presented
//   RESP   | read data returned to the owner with a one-cycle rvalid pulse
module mem_arbiter #(
  parameter logic [31:0] BTN_ADDR = 32'd1000,
  parameter logic [31:0] OUT_ADDR = 32'd2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut,
  input  logic        button_in,
  output logic        button_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;          // 0 = cpu preferred, 1 = aux preferred
  logic        owner_q, owner_d;      // 0 = cpu, 1 = aux
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        btn_snap_q, btn_snap_d;
  logic        button_q, button_d;
  logic        sync1_q, sync2_q;

  logic        win;
  logic        is_btn, is_out;
  logic [31:0] rd_val;

  assign is_btn     = (addr_q == BTN_ADDR);
  assign is_out     = (addr_q == OUT_ADDR);
  assign button_out = button_q;

  // Next-state, arbitration and output decode; outputs are suppressed while reset
  // is high so an interrupted transaction never grants, returns data or writes RAM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    btn_snap_d = btn_snap_q;
    button_d   = button_q;
    cpu_gnt    = 1'b0;
    aux_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    aux_rvalid = 1'b0;
    cpu_rdata  = '0;
    aux_rdata  = '0;
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    // With both requesting the pointer decides; otherwise the lone requester wins.
    win        = (cpu_req && aux_req) ? ptr_q : aux_req;
    rd_val     = is_btn ? {31'b0, btn_snap_q} :
                 is_out ? {31'b0, button_q}   : ram_dataOut;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || aux_req) begin
          owner_d    = win;
          we_d       = win ? aux_we    : cpu_we;
          addr_d     = win ? aux_addr  : cpu_addr;
          wdata_d    = win ? aux_wdata : cpu_wdata;
          // Button level is captured when the request is accepted.
          btn_snap_d = sync2_q;
          ptr_d      = ~win;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!reset) begin
          cpu_gnt    = ~owner_q;
          aux_gnt    = owner_q;
          ram_wEn    = we_q && !is_btn && !is_out;
          ram_addr   = addr_q[11:0];
          ram_dataIn = wdata_q;
        end
        if (we_q && is_out) begin
          button_d = wdata_q[0];
        end
        state_d = we_q ? IDLE : RESP;
      end
      RESP: begin
        if (!reset) begin
          if (owner_q) begin
            aux_rvalid = 1'b1;
            aux_rdata  = rd_val;
          end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = rd_val;
          end
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, transaction latches, output latch and button synchronizer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      btn_snap_q <= 1'b0;
      button_q   <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      btn_snap_q <= btn_snap_d;
      button_q   <= button_d;
      sync1_q    <= button_in;
      sync2_q    <= sync1_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read RAM.
module tb_mem_arbiter;

  localparam logic [31:0] BTN = 32'd1000;
  localparam logic [31:0] OUTA = 32'd2000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn, ram_dataOut;
  logic        button_in, button_out;

  logic [31:0] mem [0:4095];

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.BTN_ADDR(BTN), .OUT_ADDR(OUTA)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut),
    .button_in(button_in), .button_out(button_out)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM: data appears the cycle after the address.
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
  endtask

  // One transaction from a single requester, starting at a negedge.
  task automatic txn(input bit aux, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input string tag);
    logic [11:0] exp_addr;
    bit          exp_wen;
    exp_addr = addr[11:0];
    exp_wen  = we && (addr != BTN) && (addr != OUTA);
    if (aux) begin
      aux_req = 1; aux_we = we; aux_addr = addr; aux_wdata = wdata;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    @(negedge clock);
    chk({tag, "_gnt"},       aux ? aux_gnt : cpu_gnt, 1);
    chk({tag, "_other_gnt"}, aux ? cpu_gnt : aux_gnt, 0);
    chk({tag, "_wen"},       ram_wEn, exp_wen);
    chk({tag, "_ram_addr"},  ram_addr, exp_addr);
    chk({tag, "_ram_din"},   ram_dataIn, wdata);
    // Disturb the request fields after the grant; the transaction must not notice.
    cpu_req = 0; aux_req = 0; cpu_we = ~we; aux_we = ~we;
    cpu_addr = '1; aux_addr = '1; cpu_wdata = 0; aux_wdata = 0;
    if (!we) begin
      @(negedge clock);
      chk({tag, "_rvalid"},       aux ? aux_rvalid : cpu_rvalid, 1);
      chk({tag, "_rdata"},        aux ? aux_rdata : cpu_rdata, exp_rdata);
      chk({tag, "_other_rvalid"}, aux ? cpu_rvalid : aux_rvalid, 0);
      chk({tag, "_other_rdata"},  aux ? cpu_rdata : aux_rdata, 0);
      chk({tag, "_resp_wen"},     ram_wEn, 0);
    end
    @(negedge clock);
    chk({tag, "_idle_wen"},  ram_wEn, 0);
    chk({tag, "_idle_busy"}, {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid}, 0);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  exp_own [4] = '{0, 1, 0, 1};
    int  ngr;
    bit  seen;

    idle_inputs();
    button_in = 0;
    reset = 1;
    repeat (2) @(negedge clock);
    chk("rst_ctrl",    {cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, ram_wEn, button_out}, 0);
    chk("rst_rdata",   cpu_rdata | aux_rdata, 0);
    chk("rst_ram",     {20'b0, ram_addr} | ram_dataIn, 0);
    reset = 0;
    @(negedge clock);

    // Basic write then read back through the RAM.
    txn(0, 1, 32'd5, 32'hDEADBEEF, 0, "wr5");
    txn(0, 0, 32'd5, 0, 32'hDEADBEEF, "rd5");

    // Aux write above 4 KiB wraps onto word 5.
    txn(1, 1, 32'd4101, 32'd7, 0, "aux_wr4101");
    txn(0, 0, 32'd5, 0, 32'd7, "rd5_wrap");

    // Output latch and read-only button address.
    txn(0, 1, OUTA, 32'd1, 0, "wr_out");
    chk("button_out_set", button_out, 1);
    txn(0, 0, OUTA, 0, 32'd1, "rd_out");
    txn(0, 1, BTN, 32'd1, 0, "wr_btn");
    chk("button_out_kept", button_out, 1);
    txn(0, 0, BTN, 0, 32'd0, "rd_btn0");

    // Button read relative to the level change: needs 2 cycles of synchronizer delay.
    for (int d = 0; d < 4; d++) begin
      button_in = 0;
      repeat (4) @(negedge clock);
      button_in = 1;
      repeat (d) @(negedge clock);
      txn(0, 0, BTN, 0, (d >= 2) ? 32'd1 : 32'd0, $sformatf("btn_d%0d", d));
    end

    // Round-robin with both requesters continuously reading word 5.
    reset = 1;
    @(negedge clock);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5;
    aux_req = 1; aux_we = 0; aux_addr = 5;
    ngr = 0;
    for (int cyc = 0; cyc < 30 && ngr < 4; cyc++) begin
      @(negedge clock);
      if (cpu_rvalid || aux_rvalid)
        chk("arb_rdata", cpu_rvalid ? cpu_rdata : aux_rdata, 32'd7);
      if (cpu_gnt || aux_gnt) begin
        chk($sformatf("arb_grant%0d_aux", ngr), aux_gnt, exp_own[ngr]);
        chk($sformatf("arb_grant%0d_cpu", ngr), cpu_gnt, 1 - exp_own[ngr]);
        ngr++;
      end
    end
    chk("arb_count", ngr, 4);
    idle_inputs();
    repeat (3) @(negedge clock);

    // Reset during a read's ACCESS cycle; pointer was left on aux.
    txn(0, 1, OUTA, 32'd1, 0, "wr_out2");
    cpu_req = 1; cpu_we = 0; cpu_addr = 5;
    @(negedge clock);
    chk("abort_rd_gnt", cpu_gnt, 1);
    reset = 1;
    cpu_req = 0;
    @(negedge clock);
    chk("abort_rd_rvalid", {cpu_rvalid, aux_rvalid, cpu_gnt, aux_gnt}, 0);
    chk("abort_btn_out", button_out, 0);
    chk("abort_ram_addr", ram_addr, 0);
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5;
    aux_req = 1; aux_we = 0; aux_addr = 5;
    @(negedge clock);
    chk("abort_ptr_cpu_gnt", cpu_gnt, 1);
    chk("abort_ptr_aux_gnt", aux_gnt, 0);
    idle_inputs();
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      seen |= aux_gnt | aux_rvalid;
    end
    chk("aux_withdrawn", seen, 0);

    // Reset during a write's ACCESS cycle must block the RAM write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'h55;
    @(negedge clock);
    chk("abort_wr_wen_pre", ram_wEn, 1);
    reset = 1;
    cpu_req = 0;
    #1;
    chk("abort_wr_wen", ram_wEn, 0);
    @(negedge clock);
    reset = 0;
    idle_inputs();
    txn(0, 0, 32'd5, 0, 32'd7, "rd5_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
